uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  UART transmitter: serialises one parallel byte into a start/data/parity/stop frame on TX_OUT.
//  Transmit-side counterpart of the UART receive path, using the same frame format and parity convention.
//  PAR_TYPE=0 even: parity bit = ^data. PAR_TYPE=1 odd: parity bit = ~^data.
//  Sits between the system-side byte source and the serial line pin.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, sent LSB first
//  PRESC_W     6  width of PRESCALE input (clock cycles per bit)
// PORTS
//  CLK         in   1           system clock; all logic on rising edge
//  RST         in   1           synchronous reset, active-high
//  P_DATA      in   DATA_WIDTH  byte to send; sampled only on acceptance
//  Data_Valid  in   1           request; accepted only when busy=0 (IDLE)
//  PAR_EN      in   1           1 = insert parity bit; sampled on acceptance
//  PAR_TYPE    in   1           0 even / 1 odd; sampled on acceptance
//  PRESCALE    in   PRESC_W     cycles per bit; 0 treated as 1; sampled on acceptance
//  TX_OUT      out  1           serial line, registered, idle high
//  busy        out  1           registered, high from acceptance through last stop cycle
// BEHAVIOUR
//  Reset (RST=1 at an edge, also mid-frame): state=IDLE, TX_OUT=1, busy=0, counters=0.
//    All shadow registers clear. The frame is dropped with no partial stop bit.
//  Acceptance: Data_Valid=1 in IDLE at edge N latches P_DATA, PAR_EN, PAR_TYPE and PRESCALE.
//    At edge N: busy=1, TX_OUT=0 (start), state=START.
//    Data_Valid while busy=1 is ignored; P_DATA and the other inputs may change freely mid-frame.
//  FSM: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
//  Timing: each bit held for exactly P cycles (P = max(PRESCALE,1)).
//    Bit-timer counts 0..P-1; the state advances when timer==P-1.
//  DATA: bit index 0..DATA_WIDTH-1, LSB first. Leave when index==DATA_WIDTH-1 and timer==P-1.
//  PARITY: computed once from the latched byte at acceptance, not from live P_DATA.
//  STOP: TX_OUT=1 for P cycles. On its last cycle's edge: state=IDLE, busy=0.
//  Frame length, busy high: (DATA_WIDTH+2+PAR_EN)*P cycles. Default P=1: 11 with parity, 10 without.
//  Back-to-back: IDLE lasts at least one cycle. Data_Valid held high starts the next frame at the
//    edge after busy falls, so the line is high for P (stop) + 1 cycles between frames.
//  TX_OUT is a direct flop output, with no combinational path from any input.
//  Illegal/unreachable state encodings recover to IDLE with TX_OUT=1 and busy=0.
// STRUCTURE
//  Shared package uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP); PAR_EVEN=0, PAR_ODD=1;
//    default DATA_WIDTH. The receive-side checker uses the same parity constants.
//  Sub-module uart_tx_bit_timer: prescale counter with load, run and bit_done outputs.
//  The FSM, shift register and parity flop stay in this module.
// TESTING
//  1 Reset: RST high for 3 cycles with Data_Valid=1 -> TX_OUT=1, busy=0 throughout; no frame starts.
//  2 P_DATA=8'hA5, PAR_EN=1, PAR_TYPE=0, PRESCALE=1 -> TX_OUT per cycle 0,1,0,1,0,0,1,0,1,0,1.
//    busy is high for exactly 11 cycles.
//  3 Same byte with PAR_TYPE=1 -> parity bit 1. With PAR_EN=0 -> 10-cycle frame, no parity bit.
//  4 P_DATA=8'h00, PAR_EN=1, PAR_TYPE=0, PRESCALE=4 -> start, 8 zeros and parity 0, each 4 cycles.
//    Stop is high for 4 cycles; busy=1 for 44 cycles. PRESCALE=0 behaves identically to PRESCALE=1.
//  5 Data_Valid pulses with a new P_DATA mid-frame -> ignored and the current frame is unchanged.
//    Data_Valid held high -> second frame's start bit falls exactly 1 cycle after busy drops.
//  6 RST asserted during DATA bit 3 -> next edge TX_OUT=1, busy=0.
//    A new request after reset sends a complete, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: frame-level constants and FSM encoding shared by the UART transmit and receive paths.
package uart_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: byte-source request bundle plus the serial line and busy status.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH_DEF,
    parameter int PRESC_W = 6
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic Data_Valid;
    logic PAR_EN;
    logic PAR_TYPE;
    logic [PRESC_W-1:0] PRESCALE;
    logic TX_OUT;
    logic busy;
    modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYPE, PRESCALE, input TX_OUT, busy);
    modport slave (input P_DATA, Data_Valid, PAR_EN, PAR_TYPE, PRESCALE, output TX_OUT, busy);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts 0..P-1 per bit, latching P on load; bit_done marks the last cycle of a bit.
module uart_tx_bit_timer #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               run,
    input  logic [PRESC_W-1:0] prescale,
    output logic               bit_done
);
    logic [PRESC_W-1:0] cnt_q, cnt_d, lim_q, lim_d;
    assign bit_done = run && (cnt_q == lim_q);
    always_comb begin
        lim_d = load ? ((prescale == '0) ? '0 : prescale - 1'b1) : lim_q;
        cnt_d = load ? '0 : run ? (bit_done ? '0 : cnt_q + 1'b1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
        end
    end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises a latched byte as start, LSB-first data, optional parity and stop bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESC_W = 6
) (
    input logic CLK,
    input logic RST,
    uart_tx_frame_if.slave bus
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    tx_state_t state_q, state_d;
    logic tx_q, tx_d, busy_q, busy_d, par_q, par_d, pen_q, pen_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [IW-1:0] idx_q, idx_d;
    logic load, run, bit_done;
    uart_tx_bit_timer #(.PRESC_W(PRESC_W)) u_timer (
        .clk(CLK), .rst(RST), .load(load), .run(run), .prescale(bus.PRESCALE), .bit_done(bit_done)
    );
    assign bus.TX_OUT = tx_q;
    assign bus.busy = busy_q;
    assign run = (state_q != IDLE);
    always_comb begin
        state_d = state_q;
        tx_d = tx_q;
        busy_d = busy_q;
        sh_d = sh_q;
        idx_d = idx_q;
        par_d = par_q;
        pen_d = pen_q;
        load = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                busy_d = 1'b0;
                if (bus.Data_Valid) begin
                    state_d = START;
                    tx_d = 1'b0;
                    busy_d = 1'b1;
                    sh_d = bus.P_DATA;
                    idx_d = '0;
                    par_d = (^bus.P_DATA) ^ (bus.PAR_TYPE == PAR_ODD);
                    pen_d = bus.PAR_EN;
                    load = 1'b1;
                end
            end
            START: if (bit_done) begin
                state_d = DATA;
                tx_d = sh_q[0];
                sh_d = sh_q >> 1;
                idx_d = '0;
            end
            DATA: if (bit_done) begin
                if (idx_q == IW'(DATA_WIDTH - 1)) begin
                    state_d = pen_q ? PARITY : STOP;
                    tx_d = pen_q ? par_q : 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    tx_d = sh_q[0];
                    sh_d = sh_q >> 1;
                end
            end
            PARITY: if (bit_done) begin
                state_d = STOP;
                tx_d = 1'b1;
            end
            STOP: if (bit_done) begin
                state_d = IDLE;
                busy_d = 1'b0;
                tx_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                tx_d = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            tx_q <= 1'b1;
            busy_q <= 1'b0;
            sh_q <= '0;
            idx_q <= '0;
            par_q <= 1'b0;
            pen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q <= tx_d;
            busy_q <= busy_d;
            sh_q <= sh_d;
            idx_q <= idx_d;
            par_q <= par_d;
            pen_q <= pen_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed and randomized frames checked cycle by cycle against a bit-list model.
module tb_uart_tx_frame;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int errors = 0;
    uart_tx_frame_if bus ();
    uart_tx_frame dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level per cycle: each frame bit repeated P times, parity from a ones count.
    function automatic void build(input logic [7:0] d, input logic pen, input logic pt,
                                  input logic [5:0] ps, output bit wave[$]);
        bit bits[$];
        int ones = 0;
        int p = (ps == 0) ? 1 : int'(ps);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pen) bits.push_back(((ones % 2) == 1) != pt);
        bits.push_back(1'b1);
        wave = {};
        foreach (bits[i]) for (int k = 0; k < p; k++) wave.push_back(bits[i]);
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] d, input logic pen, input logic pt,
                             input logic [5:0] ps, input bit noise, input bit hold, input int abort_at);
        bit wave[$];
        build(d, pen, pt, ps, wave);
        bus.P_DATA = d;
        bus.PAR_EN = pen;
        bus.PAR_TYPE = pt;
        bus.PRESCALE = ps;
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = hold;
        for (int i = 0; i < wave.size(); i++) begin
            chk({tag, " tx"}, {31'd0, bus.TX_OUT}, {31'd0, wave[i]});
            chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
            if (i == abort_at) begin
                RST = 1'b1;
                bus.Data_Valid = 1'b0;
                @(negedge CLK);
                chk({tag, " rst tx"}, {31'd0, bus.TX_OUT}, 32'd1);
                chk({tag, " rst busy"}, {31'd0, bus.busy}, 32'd0);
                RST = 1'b0;
                @(negedge CLK);
                chk({tag, " post-rst idle"}, {30'd0, bus.busy, bus.TX_OUT}, 32'd1);
                return;
            end
            if (noise && i < wave.size() - 1) begin
                bus.P_DATA = 8'($urandom);
                bus.Data_Valid = 1'($urandom);
                bus.PAR_EN = 1'($urandom);
                bus.PAR_TYPE = 1'($urandom);
                bus.PRESCALE = 6'($urandom);
            end else bus.Data_Valid = hold;
            @(negedge CLK);
        end
        chk({tag, " end busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " end tx"}, {31'd0, bus.TX_OUT}, 32'd1);
    endtask

    initial begin
        bus.P_DATA = 8'h00;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYPE = 1'b0;
        bus.PRESCALE = 6'd1;
        bus.Data_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("reset", {30'd0, bus.busy, bus.TX_OUT}, 32'd1);
        end
        RST = 1'b0;
        bus.Data_Valid = 1'b0;
        @(negedge CLK);
        chk("idle", {30'd0, bus.busy, bus.TX_OUT}, 32'd1);
        run_frame("a5 even", 8'hA5, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0, -1);
        run_frame("a5 odd", 8'hA5, 1'b1, 1'b1, 6'd1, 1'b0, 1'b0, -1);
        run_frame("a5 nopar", 8'hA5, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0, -1);
        run_frame("00 p4", 8'h00, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0, -1);
        run_frame("p0", 8'h3C, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, -1);
        run_frame("noise", 8'h96, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0, -1);
        run_frame("hold1", 8'h5A, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1, -1);
        run_frame("hold2", 8'hC3, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0, -1);
        run_frame("abort", 8'hF0, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0, 4);
        run_frame("after rst", 8'h81, 1'b1, 1'b1, 6'd1, 1'b0, 1'b0, -1);
        for (int n = 0; n < 20; n++)
            run_frame("rand", 8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 5)),
                      1'($urandom), 1'($urandom_range(0, 3) == 0), -1);
        bus.Data_Valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
